// File: rtl/clkspec_muladd16_32.sv
// Sequential unsigned multiply-add: dd = qt*dv + rm.
// This is the reconstruction datapath for the 32/16 non-restoring divider.
// A shift-add engine retires one multiplier bit per clock.
// A valid/ready handshake sits on both the operand side and the result side.
// err flags operand pairs that no legal division could produce (rm >= dv).
module clkspec_muladd16_32 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,      // asynchronous, active-low
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   qt,         // multiplier (quotient)
  input  logic [WIDTH-1:0]   dv,         // multiplicand (divisor)
  input  logic [WIDTH-1:0]   rm,         // addend (remainder)
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dd,         // qt*dv + rm (dividend)
  output logic               err         // rm >= dv, meaningful while out_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   md_q, md_d;        // latched multiplicand
  logic [WIDTH-1:0]   hi_q, hi_d;        // upper accumulator, seeded with the addend
  logic [WIDTH-1:0]   lo_q, lo_d;        // multiplier bits shifting out / product bits shifting in
  logic [CW-1:0]      count_q, count_d;
  logic               err_r_q, err_r_d;
  logic [2*WIDTH-1:0] dd_q, dd_d;        // presented result, loaded only on completion
  logic               in_ready_q;
  logic               out_valid_q;

  // One shift-add step: the carry of the sum lands in hi MSB and
  // the sum LSB slides into lo MSB as the consumed multiplier bit leaves.
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_next;

  // Combinational step datapath: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    step_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    step_next = {step_sum, lo_q[WIDTH-1:1]};
  end

  // Next-state and datapath-update decode for the IDLE -> MUL -> DONE sequence.
  always_comb begin
    // NOTE: every signal is given a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    md_d    = md_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    err_r_d = err_r_q;
    dd_d    = dd_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          md_d    = dv;
          hi_d    = rm;
          lo_d    = qt;
          count_d = LAST_STEP;
          err_r_d = (rm >= dv);
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        {hi_d, lo_d} = step_next;
        if (count_q == '0) begin
          // The final step result goes straight to the output register.
          // dd therefore never shows a partial product.
          dd_d    = step_next;
          state_d = S_DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      S_DONE: begin
        // Result and err are held here until the consumer takes them.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, accumulator and step-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      err_r_q <= 1'b0;
      dd_q    <= '0;
    end else begin
      md_q    <= md_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
      err_r_q <= err_r_d;
      dd_q    <= dd_d;
    end
  end

  // Handshake outputs are registered decodes of the next state.
  // They reach their ports with no combinational path from any input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dd        = dd_q;
  assign err       = err_r_q;

endmodule

// File: tb/tb_clkspec_muladd16_32.sv
// Directed and randomized bench for the sequential multiply-add block.
// Inputs are driven on the falling edge, and outputs are sampled there as well.
module tb_clkspec_muladd16_32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] qt, dv, rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dd;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  clkspec_muladd16_32 #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .qt        (qt),
    .dv        (dv),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dd        (dd),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present one triple for exactly one accept edge.
  task automatic send(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    qt = q;
    dv = d;
    rm = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count clocks from the accept edge until out_valid; optionally toggle in_valid as noise.
  task automatic wait_result(input bit noise, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        qt = 16'($urandom);
        dv = 16'($urandom);
        rm = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("out_valid_arrives", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] q, input logic [15:0] d,
                       input logic [15:0] r, input logic [31:0] exp_dd, input logic exp_err,
                       input bit noise, output int lat);
    send(q, d, r);
    wait_result(noise, lat);
    check({tag, "_dd"}, dd, exp_dd);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (noise) repeat ($urandom_range(0, 3)) @(negedge clk);
    consume();
  endtask

  initial begin
    int          lat;
    logic [15:0] rq, rd, rr, hi16;
    logic [31:0] dividend, exp_v;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    qt = '0;
    dv = '0;
    rm = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dd", dd, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1) Basic product plus addend, with exact 16-clock latency.
    do_op("t1", 16'h1234, 16'h0100, 16'h0056, 32'h0012_3456, 1'b0, 1'b0, lat);
    check("t1_latency", lat, 32'd16);

    // 2) Maximum operands: no overflow.
    do_op("t2", 16'hFFFF, 16'hFFFF, 16'hFFFE, 32'hFFFE_FFFF, 1'b0, 1'b0, lat);

    // 3) Illegal pairs: zero divisor, and remainder equal to the divisor.
    do_op("t3a", 16'h0005, 16'h0000, 16'h0003, 32'h0000_0003, 1'b1, 1'b0, lat);
    do_op("t3b", 16'h0002, 16'h0007, 16'h0007, 32'h0000_0015, 1'b1, 1'b0, lat);

    // 4) Back-pressure: the result is held while new operands are ignored.
    send(16'h00FF, 16'h0101, 16'h0002);
    wait_result(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      qt = 16'hAAAA + 16'(i);
      dv = 16'h5555;
      rm = 16'h1111;
      @(negedge clk);
      check("t4_dd_hold", dd, 32'h0001_0001);
      check("t4_err_hold", {31'd0, err}, 32'd0);
      check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("t4_out_valid_hold", {31'd0, out_valid}, 32'd1);
    end
    consume();
    check("t4_dd_after_consume", dd, 32'h0001_0001);
    do_op("t4_next", 16'h0010, 16'h0010, 16'h000F, 32'h0000_010F, 1'b0, 1'b0, lat);

    // 5) Reset eight clocks into the multiply aborts the operation.
    send(16'h1234, 16'h5678, 16'h0001);
    repeat (7) @(negedge clk);
    check("t5_mid_mul_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_dd", dd, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op("t5_after", 16'h0003, 16'h0004, 16'h0001, 32'h0000_000D, 1'b0, 1'b0, lat);

    // 6a) Random triples with gaps and in_valid noise, checked against the plain arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      rq = 16'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rr = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      exp_v = 32'(rq) * 32'(rd) + 32'(rr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op("rand", rq, rd, rr, exp_v, (rr >= rd), 1'b1, lat);
    end

    // 6b) Round trip: divide a random dividend in the bench, then rebuild it.
    for (int i = 0; i < 50; i++) begin
      hi16     = 16'($urandom_range(0, 16'hFFFE));
      dividend = {hi16, 16'($urandom)};
      rd       = 16'($urandom_range(int'(hi16) + 1, 16'hFFFF));
      rq       = 16'(dividend / {16'h0, rd});
      rr       = 16'(dividend % {16'h0, rd});
      do_op("roundtrip", rq, rd, rr, dividend, 1'b0, 1'b1, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
